uart_rx_framed: RTL

Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds configurable data width, parity, and stop-bit count. Samples each bit at an oversampled rate with 3-sample majority voting and rejects start-bit glitches. Each received word carries per-word parity and framing error flags into an internal FIFO, drained through a valid/ready stream that feeds the command parser / DSP front end.

---
 rtl/uart_rx_framed.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_framed.sv
// UART receiver with configurable data width, parity and stop bits.
// Oversampled 3-sample majority decoding feeding a word FIFO with per-word error flags.
module uart_rx_framed #(
    parameter int CLK_MHZ    = 50,
    parameter int BAUDRATE   = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_perr,
    output logic                 m_ferr,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overflow,
    input  logic                 overflow_clr,
    output logic                 busy
);

    localparam int DIV    = CLK_MHZ * 1000000 / (BAUDRATE * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int WORD_W = DATA_BITS + 2;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SAMP_W-1:0] CNT_LO    = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] CNT_MID   = SAMP_W'(OVERSAMPLE / 2);
    localparam logic [SAMP_W-1:0] CNT_HI    = SAMP_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SAMP_W-1:0] CNT_LAST  = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic              ODD       = (PARITY == 1) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 rx_meta_r;
    logic                 rxs_r;
    logic                 armed_r;
    logic [DIV_W-1:0]     div_cnt_r;
    logic [SAMP_W-1:0]    samp_cnt_r;
    logic                 s_lo_r;
    logic                 s_mid_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic                 stop_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 perr_r;
    logic                 ferr_r;
    logic                 push_r;
    logic [WORD_W-1:0]    push_word_r;

    logic [WORD_W-1:0]    mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wptr_r;
    logic [PTR_W-1:0]     rptr_r;
    logic                 overflow_r;

    logic                 tick_s;
    logic                 decide_s;
    logic                 end_s;
    logic                 bit_s;
    logic                 start_s;
    logic                 push_now_s;
    logic                 full_s;
    logic                 empty_s;
    logic                 pop_s;
    logic                 wr_ok_s;
    logic [WORD_W-1:0]    head_s;

    assign tick_s   = (state_r != S_IDLE) && (div_cnt_r == DIV_LAST);
    assign decide_s = tick_s && (samp_cnt_r == CNT_HI);
    assign end_s    = tick_s && (samp_cnt_r == CNT_LAST);
    assign bit_s    = maj3(s_lo_r, s_mid_r, rxs_r);

    // Next-state logic; a start needs the line to have been seen high since the last frame.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        push_now_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (armed_r && !rxs_r) begin
                    state_nxt_s = S_START;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_START: begin
                if (decide_s && bit_s) begin
                    state_nxt_s = S_IDLE;
                end else if (end_s) begin
                    state_nxt_s = S_DATA;
                end else begin
                    state_nxt_s = S_START;
                end
            end
            S_DATA: begin
                if (end_s && (bit_cnt_r == BIT_LAST)) begin
                    state_nxt_s = (PARITY != 0) ? S_PAR : S_STOP;
                end else begin
                    state_nxt_s = S_DATA;
                end
            end
            S_PAR: begin
                if (end_s) begin
                    state_nxt_s = S_STOP;
                end else begin
                    state_nxt_s = S_PAR;
                end
            end
            S_STOP: begin
                // Leave mid-bit on the last stop decision so the next start edge is caught.
                if (decide_s && (stop_idx_r == STOP_LAST)) begin
                    state_nxt_s = S_IDLE;
                    push_now_s  = 1'b1;
                end else begin
                    state_nxt_s = S_STOP;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Synchroniser, bit timing and frame assembly registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r   <= 1'b1;
            rxs_r       <= 1'b1;
            state_r     <= S_IDLE;
            armed_r     <= 1'b0;
            div_cnt_r   <= '0;
            samp_cnt_r  <= '0;
            s_lo_r      <= 1'b1;
            s_mid_r     <= 1'b1;
            bit_cnt_r   <= '0;
            stop_idx_r  <= 1'b0;
            shift_r     <= '0;
            perr_r      <= 1'b0;
            ferr_r      <= 1'b0;
            push_r      <= 1'b0;
            push_word_r <= '0;
        end else begin
            rx_meta_r <= rx;
            rxs_r     <= rx_meta_r;
            state_r   <= state_nxt_s;

            if (start_s) begin
                armed_r <= 1'b0;
            end else if ((state_r == S_IDLE) && rxs_r) begin
                armed_r <= 1'b1;
            end

            if ((state_r == S_IDLE) || tick_s) begin
                div_cnt_r <= '0;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end

            if (state_r == S_IDLE) begin
                samp_cnt_r <= '0;
            end else if (tick_s) begin
                samp_cnt_r <= (samp_cnt_r == CNT_LAST) ? '0 : samp_cnt_r + SAMP_W'(1);
            end

            if (tick_s && (samp_cnt_r == CNT_LO)) begin
                s_lo_r <= rxs_r;
            end
            if (tick_s && (samp_cnt_r == CNT_MID)) begin
                s_mid_r <= rxs_r;
            end

            if (start_s) begin
                bit_cnt_r  <= '0;
                stop_idx_r <= 1'b0;
                perr_r     <= 1'b0;
                ferr_r     <= 1'b0;
            end else begin
                if ((state_r == S_DATA) && end_s) begin
                    bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                end
                if ((state_r == S_STOP) && end_s) begin
                    stop_idx_r <= 1'b1;
                end
                if ((state_r == S_PAR) && decide_s) begin
                    perr_r <= (parity_of(shift_r) ^ bit_s) != ODD;
                end
                if ((state_r == S_STOP) && decide_s && !bit_s) begin
                    ferr_r <= 1'b1;
                end
            end

            if ((state_r == S_DATA) && decide_s) begin
                shift_r <= {bit_s, shift_r[DATA_BITS-1:1]};
            end

            push_r <= push_now_s;
            if (push_now_s) begin
                push_word_r <= {ferr_r | ~bit_s, perr_r, shift_r};
            end
        end
    end

    assign empty_s = (wptr_r == rptr_r);
    assign full_s  = (wptr_r[ADDR_W-1:0] == rptr_r[ADDR_W-1:0]) &&
                     (wptr_r[ADDR_W] != rptr_r[ADDR_W]);
    assign pop_s   = !empty_s && m_ready;
    assign wr_ok_s = push_r && (!full_s || pop_s);

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wptr_r[ADDR_W-1:0]] <= push_word_r;
        end
    end

    // FIFO pointers and sticky overflow flag (a set beats a clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r     <= '0;
            rptr_r     <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wptr_r <= wptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_W'(1);
            end
            if (push_r && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end else if (overflow_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign head_s   = mem_r[rptr_r[ADDR_W-1:0]];
    assign m_data   = head_s[DATA_BITS-1:0];
    assign m_perr   = head_s[DATA_BITS];
    assign m_ferr   = head_s[DATA_BITS+1];
    assign m_valid  = !empty_s;
    assign overflow = overflow_r;
    assign busy     = (state_r != S_IDLE);

endmodule
